// File: rtl/reset_domain_pkg.sv
// Shared types and width helpers for the staged reset-release controller.
package reset_domain_pkg;

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } rdc_state_e;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // Bits needed to index count domains; a single domain still gets a 1-bit index.
   function automatic int unsigned idx_width(input int unsigned count);
      return (count <= 1) ? 1 : $clog2(count);
   endfunction

endpackage

// File: rtl/reset_domain_controller.sv
// Releases DOMAIN_COUNT reset domains one after another: hold, release, wait for
// init-complete (or time out), then move on. A reset request restarts the sequence.
module reset_domain_controller
   import reset_domain_pkg::*;
#(
   parameter int unsigned DOMAIN_COUNT  = 3,
   parameter int unsigned HOLD_CYCLE    = 8,
   parameter int unsigned TIMEOUT_CYCLE = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    resetReq,
   input  logic [DOMAIN_COUNT-1:0] initDone,
   output logic [DOMAIN_COUNT-1:0] rstOut,
   output logic                    ready,
   output logic                    busy,
   output logic                    timeoutError
);

   localparam int unsigned IW = idx_width(DOMAIN_COUNT);
   localparam int unsigned HW = cnt_width(HOLD_CYCLE);
   localparam int unsigned WW = cnt_width(TIMEOUT_CYCLE);

   localparam logic [IW-1:0] LAST_IDX   = IW'(DOMAIN_COUNT - 1);
   localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLE);
   localparam logic [WW-1:0] WAIT_LIMIT = WW'(TIMEOUT_CYCLE - 1);

   rdc_state_e    state_q;
   logic [IW-1:0] idx_q;
   logic [HW-1:0] hold_cnt_q;
   logic [WW-1:0] wait_cnt_q;
   logic          timeout_err_q;

   // NOTE: every register here is written with <= so all updates see the
   // pre-edge values, exactly like the flops they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_HOLD;
         idx_q         <= '0;
         hold_cnt_q    <= HOLD_LOAD;
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else if (resetReq) begin
         // The sticky error survives a software restart on purpose.
         state_q    <= ST_HOLD;
         idx_q      <= '0;
         hold_cnt_q <= HOLD_LOAD;
         wait_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               hold_cnt_q <= hold_cnt_q - HW'(1);
               if (hold_cnt_q == HW'(1)) begin
                  state_q    <= ST_WAIT;
                  wait_cnt_q <= '0;
               end
            end
            ST_WAIT: begin
               if (initDone[idx_q] || (wait_cnt_q == WAIT_LIMIT)) begin
                  if (!initDone[idx_q]) timeout_err_q <= 1'b1;
                  if (idx_q == LAST_IDX) begin
                     state_q <= ST_DONE;
                  end else begin
                     idx_q      <= idx_q + IW'(1);
                     hold_cnt_q <= HOLD_LOAD;
                     state_q    <= ST_HOLD;
                  end
               end else begin
                  wait_cnt_q <= wait_cnt_q + WW'(1);
               end
            end
            ST_DONE: ;
            default: begin
               state_q    <= ST_HOLD;
               idx_q      <= '0;
               hold_cnt_q <= HOLD_LOAD;
               wait_cnt_q <= '0;
            end
         endcase
      end
   end

   // NOTE: rstOut gets a full default before the loop, so no bit can be left
   // unassigned on some path and turn into a latch.
   always_comb begin
      rstOut = '0;
      for (int i = 0; i < DOMAIN_COUNT; i++) begin
         rstOut[i] = ((state_q == ST_HOLD) && (IW'(i) >= idx_q)) ||
                     ((state_q == ST_WAIT) && (IW'(i) >  idx_q));
      end
   end

   assign ready        = (state_q == ST_DONE);
   assign busy         = (state_q != ST_DONE);
   assign timeoutError = timeout_err_q;

endmodule

// File: tb/tb_reset_domain_controller.sv
// Bench for reset_domain_controller: three configurations checked every cycle
// against an elapsed-time model, plus directed cycle-exact expectations.
module tb_reset_domain_controller;

   localparam int NI = 3;
   localparam int P_N  [NI] = '{3, 3, 1};
   localparam int P_H  [NI] = '{8, 8, 1};
   localparam int P_TO [NI] = '{1024, 16, 1024};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, req_a, ready_a, busy_a, terr_a;
   logic [2:0] init_a, rstout_a;
   logic       rst_t, req_t, ready_t, busy_t, terr_t;
   logic [2:0] init_t, rstout_t;
   logic       rst_s, req_s, ready_s, busy_s, terr_s;
   logic [0:0] init_s, rstout_s;

   reset_domain_controller dut_a (
      .clk(clk), .rst(rst_a), .resetReq(req_a), .initDone(init_a),
      .rstOut(rstout_a), .ready(ready_a), .busy(busy_a), .timeoutError(terr_a)
   );

   reset_domain_controller #(.DOMAIN_COUNT(3), .HOLD_CYCLE(8), .TIMEOUT_CYCLE(16)) dut_t (
      .clk(clk), .rst(rst_t), .resetReq(req_t), .initDone(init_t),
      .rstOut(rstout_t), .ready(ready_t), .busy(busy_t), .timeoutError(terr_t)
   );

   reset_domain_controller #(.DOMAIN_COUNT(1), .HOLD_CYCLE(1)) dut_s (
      .clk(clk), .rst(rst_s), .resetReq(req_s), .initDone(init_s),
      .rstOut(rstout_s), .ready(ready_s), .busy(busy_s), .timeoutError(terr_s)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int c        = 0;

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: actual %b, required %b", name, $time, act, exp);
      end
   endtask

   // Model: current domain, cycles elapsed since its hold began, done, sticky error.
   int  mk [NI];
   int  me [NI];
   bit  mdone [NI];
   bit  mterr [NI];
   bit  mvalid [NI];

   task automatic model_step(input int i, input logic r, input logic q, input logic [2:0] ini);
      bit ok;
      if (r) begin
         mk[i] = 0; me[i] = 0; mdone[i] = 0; mterr[i] = 0; mvalid[i] = 1;
      end else if (!mvalid[i]) begin
         mvalid[i] = 0;
      end else if (q) begin
         mk[i] = 0; me[i] = 0; mdone[i] = 0;
      end else if (!mdone[i]) begin
         if (me[i] < P_H[i]) begin
            me[i]++;
         end else begin
            ok = (ini[mk[i]] === 1'b1);
            if (ok || (me[i] - P_H[i] == P_TO[i] - 1)) begin
               if (!ok) mterr[i] = 1;
               if (mk[i] == P_N[i] - 1) mdone[i] = 1;
               else begin
                  mk[i]++;
                  me[i] = 0;
               end
            end else begin
               me[i]++;
            end
         end
      end
   endtask

   function automatic logic [2:0] exp_rst(input int i);
      logic [2:0] v;
      v = '0;
      if (!mdone[i])
         for (int b = 0; b < P_N[i]; b++)
            v[b] = (me[i] < P_H[i]) ? (b >= mk[i]) : (b > mk[i]);
      return v;
   endfunction

   task automatic cmp_inst(input int i, input string tag, input logic [2:0] r,
                           input logic rd, input logic bs, input logic te);
      check({tag, ".rstOut"}, r, exp_rst(i));
      check({tag, ".ready"}, 3'(rd), 3'(mdone[i]));
      check({tag, ".busy"}, 3'(bs), 3'(!mdone[i]));
      check({tag, ".timeoutError"}, 3'(te), 3'(mterr[i]));
   endtask

   always @(posedge clk) begin
      model_step(0, rst_a, req_a, init_a);
      model_step(1, rst_t, req_t, init_t);
      model_step(2, rst_s, req_s, {2'b00, init_s});
   end

   always @(negedge clk) begin
      if (mvalid[0]) cmp_inst(0, "A", rstout_a, ready_a, busy_a, terr_a);
      if (mvalid[1]) cmp_inst(1, "T", rstout_t, ready_t, busy_t, terr_t);
      if (mvalid[2]) cmp_inst(2, "S", 3'(rstout_s), ready_s, busy_s, terr_s);
   end

   task automatic goto(input int target);
      while (c < target) begin
         @(negedge clk);
         c++;
      end
   endtask

   // Hold rst for three edges; on return we are in cycle 1 of the new sequence.
   task automatic restart_a();
      rst_a = 1'b1;
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      c = 1;
   endtask

   initial begin
      rst_a = 1'b1; req_a = 1'b0; init_a = 3'b111;
      rst_t = 1'b1; req_t = 1'b0; init_t = 3'b110;
      rst_s = 1'b1; req_s = 1'b0; init_s = 1'b0;

      // All initDone high: domains release at cycles 9, 18, 27.
      repeat (3) @(negedge clk);
      check("A.reset.rstOut", rstout_a, 3'b111);
      check("A.reset.ready", 3'(ready_a), 3'd0);
      check("A.reset.busy", 3'(busy_a), 3'd1);
      check("A.reset.timeoutError", 3'(terr_a), 3'd0);
      rst_a = 1'b0;
      c = 1;
      check("A.c1.rstOut", rstout_a, 3'b111);
      goto(8);  check("A.c8.rstOut", rstout_a, 3'b111);
      goto(9);  check("A.c9.rstOut", rstout_a, 3'b110);
      goto(17); check("A.c17.rstOut", rstout_a, 3'b110);
      goto(18); check("A.c18.rstOut", rstout_a, 3'b100);
      goto(26); check("A.c26.rstOut", rstout_a, 3'b100);
      goto(27); check("A.c27.rstOut", rstout_a, 3'b000);
      goto(28); check("A.c28.ready", 3'(ready_a), 3'd1);
      check("A.c28.busy", 3'(busy_a), 3'd0);

      // initDone[1] arrives five cycles into domain 1's wait.
      init_a = 3'b101;
      restart_a();
      goto(23); check("A.late.c23.rstOut", rstout_a, 3'b100);
      init_a = 3'b111;
      goto(24); check("A.late.c24.rstOut", rstout_a, 3'b100);
      goto(31); check("A.late.c31.rstOut", rstout_a, 3'b100);
      goto(32); check("A.late.c32.rstOut", rstout_a, 3'b000);
      goto(33); check("A.late.c33.ready", 3'(ready_a), 3'd1);

      // resetReq in domain 1's wait, coincident with initDone[1].
      init_a = 3'b101;
      restart_a();
      goto(20); check("A.req.c20.rstOut", rstout_a, 3'b100);
      req_a = 1'b1; init_a = 3'b111;
      goto(21); check("A.req.c21.rstOut", rstout_a, 3'b111);
      check("A.req.c21.ready", 3'(ready_a), 3'd0);
      req_a = 1'b0;
      goto(28); check("A.req.c28.rstOut", rstout_a, 3'b111);
      goto(29); check("A.req.c29.rstOut", rstout_a, 3'b110);
      goto(38); check("A.req.c38.rstOut", rstout_a, 3'b100);
      goto(47); check("A.req.c47.rstOut", rstout_a, 3'b000);
      goto(48); check("A.req.c48.ready", 3'(ready_a), 3'd1);

      // resetReq held four cycles while DONE.
      goto(50); req_a = 1'b1;
      goto(51); check("A.done.c51.rstOut", rstout_a, 3'b111);
      check("A.done.c51.busy", 3'(busy_a), 3'd1);
      goto(54); check("A.done.c54.rstOut", rstout_a, 3'b111);
      req_a = 1'b0;
      goto(61); check("A.done.c61.rstOut", rstout_a, 3'b111);
      goto(62); check("A.done.c62.rstOut", rstout_a, 3'b110);

      // TIMEOUT_CYCLE=16, domain 0 never reports init.
      rst_t = 1'b1;
      repeat (3) @(negedge clk);
      check("T.reset.timeoutError", 3'(terr_t), 3'd0);
      rst_t = 1'b0;
      c = 1;
      goto(24); check("T.c24.rstOut", rstout_t, 3'b110);
      check("T.c24.timeoutError", 3'(terr_t), 3'd0);
      goto(25); check("T.c25.rstOut", rstout_t, 3'b110);
      check("T.c25.timeoutError", 3'(terr_t), 3'd1);
      goto(42); check("T.c42.rstOut", rstout_t, 3'b000);
      goto(43); check("T.c43.ready", 3'(ready_t), 3'd1);
      check("T.c43.timeoutError", 3'(terr_t), 3'd1);
      goto(45); req_t = 1'b1;
      goto(46); check("T.c46.rstOut", rstout_t, 3'b111);
      check("T.c46.timeoutError", 3'(terr_t), 3'd1);
      req_t = 1'b0;
      goto(48); rst_t = 1'b1;
      goto(49); check("T.c49.timeoutError", 3'(terr_t), 3'd0);
      check("T.c49.rstOut", rstout_t, 3'b111);
      rst_t = 1'b0;

      // Single domain, one-cycle hold.
      rst_s = 1'b1;
      repeat (3) @(negedge clk);
      check("S.reset.rstOut", 3'(rstout_s), 3'd1);
      rst_s = 1'b0;
      c = 1;
      check("S.c1.rstOut", 3'(rstout_s), 3'd1);
      goto(2); check("S.c2.rstOut", 3'(rstout_s), 3'd0);
      check("S.c2.ready", 3'(ready_s), 3'd0);
      goto(4); check("S.c4.ready", 3'(ready_s), 3'd0);
      init_s = 1'b1;
      goto(5); check("S.c5.ready", 3'(ready_s), 3'd1);
      check("S.c5.busy", 3'(busy_s), 3'd0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
